// File: rtl/miner_uart_reporter.sv
// miner_uart_reporter: prints miner results as ASCII hex over an 8N1 UART.
// Ports: clk, rst (sync, high), found/exhausted status, nonce_in/hash_in
// result, uart_tx line, busy flag, drop_count of found events lost while busy.
module miner_uart_reporter #(
  parameter int CLK_HZ       = 100_000_000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = CLK_HZ / BAUD
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         found,
  input  logic         exhausted,
  input  logic [31:0]  nonce_in,
  input  logic [255:0] hash_in,
  output logic         uart_tx,
  output logic         busy,
  output logic [7:0]   drop_count
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, SEND_F, SEND_E} state_t;
  typedef enum logic [1:0] {START, DATA, STOP} phase_t;

  state_t         state, state_n;
  phase_t         phase, phase_n;
  logic [CW-1:0]  baud_cnt, baud_n;
  logic [2:0]     bit_idx, bit_n;
  logic [6:0]     char_idx, char_n;
  logic           exh_pending, pend_n;
  logic [7:0]     drop_n;
  logic           found_q, exh_q;
  logic [31:0]    shadow_nonce;
  logic [255:0]   shadow_hash;
  logic           load;
  logic           found_ev, exh_ev;
  logic           last_char;
  logic [6:0]     nk, hk;
  logic [3:0]     nonce_nib, hash_nib;
  logic [7:0]     ch;

  function automatic logic [7:0] hex(input logic [3:0] n);
    if (n < 4'd10) return {4'h3, n};
    return {4'h0, n} + 8'h37;
  endfunction

  assign found_ev = found & ~found_q;
  assign exh_ev   = exhausted & ~exh_q;
  assign busy     = (state != IDLE);

  // 255-4k equals {~k, 2'b11} for the nibble index k
  always_comb begin
    nk        = char_idx - 7'd2;
    hk        = char_idx - 7'd11;
    nonce_nib = shadow_nonce[{~nk[2:0], 2'b11} -: 4];
    hash_nib  = shadow_hash[{~hk[5:0], 2'b11} -: 4];
    ch        = 8'h0A;
    if (state == SEND_E) begin
      unique case (1'b1)
        char_idx == 7'd0: ch = 8'h45;
        char_idx == 7'd1: ch = 8'h0D;
        default:          ch = 8'h0A;
      endcase
    end else begin
      unique case (1'b1)
        char_idx == 7'd0:                      ch = 8'h46;
        char_idx == 7'd1 || char_idx == 7'd10: ch = 8'h20;
        char_idx >= 7'd2 && char_idx <= 7'd9:  ch = hex(nonce_nib);
        char_idx >= 7'd11 && char_idx <= 7'd74: ch = hex(hash_nib);
        char_idx == 7'd75:                     ch = 8'h0D;
        default:                               ch = 8'h0A;
      endcase
    end
  end

  assign last_char = (state == SEND_F) ? (char_idx == 7'd76)
                                       : (char_idx == 7'd2);

  always_comb begin
    uart_tx = 1'b1;
    if (state != IDLE) begin
      unique case (phase)
        START:   uart_tx = 1'b0;
        DATA:    uart_tx = ch[bit_idx];
        default: uart_tx = 1'b1;
      endcase
    end
  end

  always_comb begin
    state_n = state;
    phase_n = phase;
    baud_n  = baud_cnt;
    bit_n   = bit_idx;
    char_n  = char_idx;
    pend_n  = exh_pending;
    drop_n  = drop_count;
    load    = 1'b0;
    unique case (state)
      IDLE: begin
        phase_n = START;
        baud_n  = '0;
        bit_n   = '0;
        char_n  = '0;
        if (found_ev) begin
          state_n = SEND_F;
          load    = 1'b1;
          pend_n  = exh_pending | exh_ev;
        end else if (exh_ev || exh_pending) begin
          state_n = SEND_E;
          pend_n  = 1'b0;
        end
      end
      default: begin
        if (found_ev && drop_count != 8'hFF) drop_n = drop_count + 8'd1;
        if (exh_ev) pend_n = 1'b1;
        if (baud_cnt == BAUD_LAST) begin
          baud_n = '0;
          unique case (phase)
            START: begin
              phase_n = DATA;
              bit_n   = '0;
            end
            DATA: begin
              bit_n = bit_idx + 3'd1;
              if (bit_idx == 3'd7) phase_n = STOP;
            end
            default: begin
              phase_n = START;
              bit_n   = '0;
              if (!last_char) begin
                char_n = char_idx + 7'd1;
              end else if (pend_n) begin
                // pending report follows with no idle gap
                state_n = SEND_E;
                char_n  = '0;
                pend_n  = 1'b0;
              end else begin
                state_n = IDLE;
                char_n  = '0;
              end
            end
          endcase
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      phase       <= START;
      baud_cnt    <= '0;
      bit_idx     <= '0;
      char_idx    <= '0;
      exh_pending <= 1'b0;
      drop_count  <= '0;
      found_q     <= 1'b0;
      exh_q       <= 1'b0;
    end else begin
      state       <= state_n;
      phase       <= phase_n;
      baud_cnt    <= baud_n;
      bit_idx     <= bit_n;
      char_idx    <= char_n;
      exh_pending <= pend_n;
      drop_count  <= drop_n;
      found_q     <= found;
      exh_q       <= exhausted;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_nonce <= '0;
      shadow_hash  <= '0;
    end else if (load) begin
      shadow_nonce <= nonce_in;
      shadow_hash  <= hash_in;
    end
  end

endmodule

// File: tb/tb_miner_uart_reporter.sv
// tb_miner_uart_reporter: drives miner status and decodes the UART line,
// comparing received bytes and busy timing with a reference model.
module tb_miner_uart_reporter;

  localparam int CPB = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         found = 1'b0;
  logic         exhausted = 1'b0;
  logic [31:0]  nonce_in = '0;
  logic [255:0] hash_in = '0;
  logic         uart_tx;
  logic         busy;
  logic [7:0]   drop_count;

  always #5 clk = ~clk;

  miner_uart_reporter #(
    .CLK_HZ(400),
    .BAUD(100),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .found(found),
    .exhausted(exhausted),
    .nonce_in(nonce_in),
    .hash_in(hash_in),
    .uart_tx(uart_tx),
    .busy(busy),
    .drop_count(drop_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0] rx[$];
  logic [7:0] exp_q[$];
  int starts[$];
  int busy_cyc = 0;
  int rises = 0;
  int ferr = 0;
  int cyc = 0;
  logic bprev = 1'b0;
  logic dact = 1'b0;
  int dcnt = 0;
  logic [7:0] dbyte = '0;

  // line monitor: UART decoder plus busy statistics
  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      dact = 1'b0;
    end else begin
      if (busy) busy_cyc++;
      if (busy && !bprev) rises++;
      if (!dact) begin
        if (uart_tx == 1'b0) begin
          dact = 1'b1;
          dcnt = 0;
          starts.push_back(cyc);
        end
      end else begin
        dcnt++;
        if (dcnt % CPB == CPB / 2) begin
          if (dcnt / CPB == 0) begin
            if (uart_tx) ferr++;
          end else if (dcnt / CPB <= 8) begin
            dbyte[dcnt / CPB - 1] = uart_tx;
          end else begin
            if (!uart_tx) ferr++;
            rx.push_back(dbyte);
            dact = 1'b0;
          end
        end
      end
    end
    bprev = busy;
  end

  function automatic logic [7:0] hexc(int v);
    if (v < 10) return 8'(48 + v);
    return 8'(55 + v);
  endfunction

  task automatic add_f(logic [31:0] n, logic [255:0] h);
    exp_q.push_back(8'h46);
    exp_q.push_back(8'h20);
    for (int k = 0; k < 8; k++)
      exp_q.push_back(hexc(int'((n >> (28 - 4 * k)) & 32'hF)));
    exp_q.push_back(8'h20);
    for (int k = 0; k < 64; k++)
      exp_q.push_back(hexc(int'((h >> (252 - 4 * k)) & 256'hF)));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic add_e();
    exp_q.push_back(8'h45);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic clear_mon();
    rx.delete();
    exp_q.delete();
    starts.delete();
    busy_cyc = 0;
    rises = 0;
    ferr = 0;
  endtask

  task automatic compare_rx(string tag);
    int bad;
    bad = 0;
    check({tag, "_len"}, rx.size(), exp_q.size());
    foreach (exp_q[i]) begin
      if (i >= rx.size() || rx[i] !== exp_q[i]) begin
        if (bad == 0 && i < rx.size())
          $display("FAIL %s_byte%0d: got %0h expected %0h",
                   tag, i, rx[i], exp_q[i]);
        bad++;
      end
    end
    check({tag, "_bytes"}, bad, 0);
    check({tag, "_frame"}, ferr, 0);
  endtask

  task automatic wait_idle(string tag);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (busy && n < 5000);
    check({tag, "_timeout"}, busy, 1'b0);
  endtask

  task automatic idle_cycles(int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [255:0] rand_hash();
    logic [255:0] h;
    h = '0;
    for (int i = 0; i < 8; i++) h = {h[223:0], 32'($urandom())};
    return h;
  endfunction

  logic [31:0]  n0;
  logic [255:0] h0;
  logic         both;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_tx", uart_tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_drop", drop_count, 8'd0);
    rst = 1'b0;
    idle_cycles(5);

    // fixed found message
    clear_mon();
    nonce_in = 32'h0000_00A5;
    hash_in  = {4{64'h0123_4567_89AB_CDEF}};
    add_f(nonce_in, hash_in);
    found = 1'b1;
    @(posedge clk);
    #1;
    check("f_lat_busy", busy, 1'b1);
    check("f_lat_tx", uart_tx, 1'b0);
    wait_idle("f");
    compare_rx("f");
    check("f_busy_cyc", busy_cyc, 3080);
    @(negedge clk);
    found = 1'b0;
    idle_cycles(10);

    // exhausted alone
    clear_mon();
    add_e();
    exhausted = 1'b1;
    @(posedge clk);
    #1;
    check("e_lat_busy", busy, 1'b1);
    wait_idle("e");
    idle_cycles(10);
    compare_rx("e");
    check("e_busy_cyc", busy_cyc, 120);
    check("e_idle_tx", uart_tx, 1'b1);
    exhausted = 1'b0;
    idle_cycles(10);

    // simultaneous found and exhausted
    clear_mon();
    n0 = $urandom();
    h0 = rand_hash();
    nonce_in = n0;
    hash_in = h0;
    add_f(n0, h0);
    add_e();
    found = 1'b1;
    exhausted = 1'b1;
    @(posedge clk);
    wait_idle("fe");
    compare_rx("fe");
    check("fe_busy_cyc", busy_cyc, 3200);
    check("fe_rises", rises, 1);
    if (starts.size() >= 78)
      check("fe_gap", starts[77] - starts[76], 10 * CPB);
    else
      check("fe_starts", starts.size(), 80);
    @(negedge clk);
    found = 1'b0;
    exhausted = 1'b0;
    idle_cycles(10);

    // drops during a message; shadow must hold
    clear_mon();
    nonce_in = 32'h0000_00A5;
    h0 = rand_hash();
    hash_in = h0;
    add_f(32'h0000_00A5, h0);
    found = 1'b1;
    idle_cycles(50);
    nonce_in = 32'hFFFF_FFFF;
    hash_in = rand_hash();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      found = 1'b0;
      @(negedge clk);
      found = 1'b1;
    end
    idle_cycles(2);
    check("drop3", drop_count, 8'd3);
    wait_idle("d");
    compare_rx("d");
    @(negedge clk);
    found = 1'b0;
    idle_cycles(10);

    // saturation: 297 further drops -> 300 total
    clear_mon();
    nonce_in = $urandom();
    found = 1'b1;
    idle_cycles(10);
    for (int i = 0; i < 297; i++) begin
      @(negedge clk);
      found = 1'b0;
      @(negedge clk);
      found = 1'b1;
    end
    idle_cycles(2);
    check("drop_sat", drop_count, 8'd255);
    wait_idle("s");
    check("s_len", rx.size(), 77);
    @(negedge clk);
    found = 1'b0;
    idle_cycles(10);

    // reset at byte 10, bit 4
    clear_mon();
    nonce_in = $urandom();
    hash_in = rand_hash();
    found = 1'b1;
    idle_cycles(10 * 10 * CPB + 5 * CPB);
    rst = 1'b1;
    found = 1'b0;
    @(posedge clk);
    #1;
    check("mr_tx", uart_tx, 1'b1);
    check("mr_busy", busy, 1'b0);
    check("mr_drop", drop_count, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    idle_cycles(10);
    clear_mon();
    n0 = $urandom();
    h0 = rand_hash();
    nonce_in = n0;
    hash_in = h0;
    add_f(n0, h0);
    found = 1'b1;
    @(posedge clk);
    wait_idle("mr2");
    compare_rx("mr2");
    @(negedge clk);
    found = 1'b0;
    idle_cycles(10);

    // found held across reset release
    clear_mon();
    n0 = $urandom();
    h0 = rand_hash();
    nonce_in = n0;
    hash_in = h0;
    add_f(n0, h0);
    found = 1'b1;
    rst = 1'b1;
    idle_cycles(3);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("hold_busy", busy, 1'b1);
    wait_idle("hold");
    idle_cycles(300);
    compare_rx("hold");
    check("hold_rises", rises, 1);
    check("hold_idle", busy, 1'b0);
    found = 1'b0;
    idle_cycles(10);

    // random messages, optionally with a simultaneous exhausted
    for (int t = 0; t < 3; t++) begin
      clear_mon();
      n0 = $urandom();
      h0 = rand_hash();
      both = 1'($urandom_range(0, 1));
      nonce_in = n0;
      hash_in = h0;
      add_f(n0, h0);
      if (both) add_e();
      found = 1'b1;
      exhausted = both;
      @(posedge clk);
      wait_idle("rnd");
      compare_rx("rnd");
      check("rnd_busy_cyc", busy_cyc, both ? 3200 : 3080);
      @(negedge clk);
      found = 1'b0;
      exhausted = 1'b0;
      idle_cycles(10);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
